pipe_vec_elastic: RTL and testbench

Parametrised N-stage valid/ready pipeline delay line, the successor to the fixed register delay chain.
- Adds per-stage valid tracking, downstream backpressure, bubble collapsing, synchronous flush, occupancy output and optional data reset.
- Sits between producer/consumer stages of the barrel core, e.g. instruction fetch to decode or the writeback return path, where a squash must drop in-flight items.

---
 rtl/pipe_vec_elastic.sv | 112 +++++++++++
 tb/tb_pipe_vec_elastic.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_vec_elastic.sv
// Elastic N-stage valid/ready delay line with bubble collapsing, synchronous flush
// and occupancy count. Item order is preserved; only flush discards items.
module pipe_vec_elastic #(
   parameter int unsigned DWIDTH     = 8,
   parameter int unsigned N          = 2,
   parameter bit          RESET_DATA = 1'b0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_valid,
   output logic                    i_ready,
   input  logic [DWIDTH-1:0]       i_data,
   input  logic                    i_flush,
   output logic                    o_valid,
   input  logic                    o_ready,
   output logic [DWIDTH-1:0]       o_data,
   output logic [$clog2(N+1)-1:0]  o_count
);

   localparam int unsigned CW = $clog2(N + 1);

   if (N < 1) begin : gen_bad_n
      $error("pipe_vec_elastic: N must be >= 1");
   end
   if (DWIDTH < 1) begin : gen_bad_dwidth
      $error("pipe_vec_elastic: DWIDTH must be >= 1");
   end

   logic [N-1:0]      valid_q;
   logic [N-1:0]      valid_d;
   logic [DWIDTH-1:0] data_q   [N];
   logic [DWIDTH-1:0] src_data [N];
   logic [N-1:0]      src_valid;
   logic [N-1:0]      load;
   logic [N:0]        rdy;
   logic              chain;

   // Stage k may advance if it is empty or everything downstream is moving.
   // Accumulated through a scalar so the chain has no self-referencing vector.
   always_comb begin
      chain  = o_ready;
      rdy    = '0;
      rdy[N] = o_ready;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         chain  = chain | ~valid_q[k];
         rdy[k] = chain;
      end
   end

   always_comb begin
      src_valid    = '0;
      src_valid[0] = i_valid;
      src_data[0]  = i_data;
      for (int k = 1; k < int'(N); k++) begin
         src_valid[k] = valid_q[k-1];
         src_data[k]  = data_q[k-1];
      end
   end

   always_comb begin
      valid_d = valid_q;
      load    = '0;
      for (int k = 0; k < int'(N); k++) begin
         if (rdy[k]) begin
            valid_d[k] = src_valid[k];
         end
         // Data only moves with a real item; bubbles leave the register untouched.
         load[k] = rdy[k] & src_valid[k];
      end
      if (i_flush) begin
         valid_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   for (genvar k = 0; k < int'(N); k++) begin : gen_stage
      if (RESET_DATA) begin : gen_data_rst
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               data_q[k] <= '0;
            end else if (load[k]) begin
               data_q[k] <= src_data[k];
            end
         end
      end else begin : gen_data_norst
         always_ff @(posedge clk) begin
            if (load[k]) begin
               data_q[k] <= src_data[k];
            end
         end
      end
   end

   always_comb begin
      o_count = '0;
      for (int k = 0; k < int'(N); k++) begin
         o_count = o_count + CW'(valid_q[k]);
      end
   end

   assign i_ready = rdy[0];
   assign o_valid = valid_q[N-1];
   assign o_data  = data_q[N-1];

endmodule

// File: tb/tb_pipe_vec_elastic.sv
// Directed bench for pipe_vec_elastic: a N=3 instance with data reset and a
// N=4 instance without, exercising latency, backpressure, bubbles, flush and reset.
module tb_pipe_vec_elastic;

   logic       clk;
   logic       reset;

   logic       a_i_valid, a_i_ready, a_i_flush, a_o_valid, a_o_ready;
   logic [7:0] a_i_data, a_o_data;
   logic [1:0] a_o_count;

   logic       b_i_valid, b_i_ready, b_i_flush, b_o_valid, b_o_ready;
   logic [7:0] b_i_data, b_o_data;
   logic [2:0] b_o_count;

   int errors = 0;
   int checks = 0;

   pipe_vec_elastic #(.DWIDTH(8), .N(3), .RESET_DATA(1'b1)) u_dut_a (
      .clk     (clk),
      .reset   (reset),
      .i_valid (a_i_valid),
      .i_ready (a_i_ready),
      .i_data  (a_i_data),
      .i_flush (a_i_flush),
      .o_valid (a_o_valid),
      .o_ready (a_o_ready),
      .o_data  (a_o_data),
      .o_count (a_o_count)
   );

   pipe_vec_elastic #(.DWIDTH(8), .N(4), .RESET_DATA(1'b0)) u_dut_b (
      .clk     (clk),
      .reset   (reset),
      .i_valid (b_i_valid),
      .i_ready (b_i_ready),
      .i_data  (b_i_data),
      .i_flush (b_i_flush),
      .o_valid (b_o_valid),
      .o_ready (b_o_ready),
      .o_data  (b_o_data),
      .o_count (b_o_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (a_o_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid got=%b exp=0", a_o_valid); end
      checks++; if (a_o_count !== 2'd0) begin errors++; $display("FAIL rst_a_count got=%0d exp=0", a_o_count); end
      checks++; if (a_o_data !== 8'h00) begin errors++; $display("FAIL rst_a_data got=%h exp=00", a_o_data); end
      checks++; if (a_i_ready !== 1'b1) begin errors++; $display("FAIL rst_a_iready got=%b exp=1", a_i_ready); end
      checks++; if (b_o_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid got=%b exp=0", b_o_valid); end
      checks++; if (b_o_count !== 3'd0) begin errors++; $display("FAIL rst_b_count got=%0d exp=0", b_o_count); end
      checks++; if (b_i_ready !== 1'b1) begin errors++; $display("FAIL rst_b_iready got=%b exp=1", b_i_ready); end
      @(negedge clk);
      reset = 1'b0;
      step();
   endtask

   task automatic test_latency();
      logic [7:0] vin [3];
      vin[0] = 8'h11; vin[1] = 8'h22; vin[2] = 8'h33;
      a_o_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_i_valid = 1'b1;
         a_i_data  = vin[i];
         step();
         checks++; if (a_o_valid !== (i == 2)) begin errors++; $display("FAIL lat_valid[%0d] got=%b exp=%b", i, a_o_valid, (i == 2)); end
         checks++; if (a_o_count !== 2'(i + 1)) begin errors++; $display("FAIL lat_count[%0d] got=%0d exp=%0d", i, a_o_count, i + 1); end
      end
      a_i_valid = 1'b0;
      checks++; if (a_o_data !== 8'h11) begin errors++; $display("FAIL lat_out0 got=%h exp=11", a_o_data); end
      step();
      checks++; if (a_o_valid !== 1'b1 || a_o_data !== 8'h22) begin errors++; $display("FAIL lat_out1 got=%b/%h exp=1/22", a_o_valid, a_o_data); end
      checks++; if (a_o_count !== 2'd2) begin errors++; $display("FAIL lat_cnt1 got=%0d exp=2", a_o_count); end
      step();
      checks++; if (a_o_valid !== 1'b1 || a_o_data !== 8'h33) begin errors++; $display("FAIL lat_out2 got=%b/%h exp=1/33", a_o_valid, a_o_data); end
      step();
      checks++; if (a_o_valid !== 1'b0 || a_o_count !== 2'd0) begin errors++; $display("FAIL lat_empty got=%b/%0d exp=0/0", a_o_valid, a_o_count); end
   endtask

   task automatic test_backpressure();
      logic [7:0] vin [3];
      vin[0] = 8'hA1; vin[1] = 8'hA2; vin[2] = 8'hA3;
      a_o_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a_i_valid = 1'b1;
         a_i_data  = vin[i];
         checks++; if (a_i_ready !== 1'b1) begin errors++; $display("FAIL bp_accept[%0d] got=%b exp=1", i, a_i_ready); end
         step();
      end
      checks++; if (a_i_ready !== 1'b0) begin errors++; $display("FAIL bp_full_iready got=%b exp=0", a_i_ready); end
      checks++; if (a_o_count !== 2'd3) begin errors++; $display("FAIL bp_count got=%0d exp=3", a_o_count); end
      step();
      a_i_valid = 1'b0;
      checks++; if (a_o_valid !== 1'b1 || a_o_data !== 8'hA1) begin errors++; $display("FAIL bp_stable got=%b/%h exp=1/a1", a_o_valid, a_o_data); end
      checks++; if (a_o_count !== 2'd3) begin errors++; $display("FAIL bp_hold_count got=%0d exp=3", a_o_count); end
      a_o_ready = 1'b1;
      #1;
      checks++; if (a_i_ready !== 1'b1) begin errors++; $display("FAIL bp_comb_iready got=%b exp=1", a_i_ready); end
      for (int i = 1; i < 3; i++) begin
         step();
         checks++; if (a_o_valid !== 1'b1 || a_o_data !== vin[i]) begin errors++; $display("FAIL bp_drain[%0d] got=%b/%h exp=1/%h", i, a_o_valid, a_o_data, vin[i]); end
      end
      step();
      checks++; if (a_o_valid !== 1'b0 || a_o_count !== 2'd0) begin errors++; $display("FAIL bp_empty got=%b/%0d exp=0/0", a_o_valid, a_o_count); end
   endtask

   task automatic test_bubble();
      b_o_ready = 1'b0;
      b_i_valid = 1'b1; b_i_data = 8'h05;
      step();
      b_i_valid = 1'b0;
      step();
      step();
      b_i_valid = 1'b1; b_i_data = 8'h06;
      step();
      b_i_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      checks++; if (b_o_count !== 3'd2) begin errors++; $display("FAIL bub_count got=%0d exp=2", b_o_count); end
      checks++; if (b_o_valid !== 1'b1 || b_o_data !== 8'h05) begin errors++; $display("FAIL bub_head got=%b/%h exp=1/05", b_o_valid, b_o_data); end
      checks++; if (b_i_ready !== 1'b1) begin errors++; $display("FAIL bub_iready got=%b exp=1", b_i_ready); end
      b_o_ready = 1'b1;
      step();
      checks++; if (b_o_valid !== 1'b1 || b_o_data !== 8'h06) begin errors++; $display("FAIL bub_second got=%b/%h exp=1/06", b_o_valid, b_o_data); end
      checks++; if (b_o_count !== 3'd1) begin errors++; $display("FAIL bub_count1 got=%0d exp=1", b_o_count); end
      step();
      checks++; if (b_o_valid !== 1'b0 || b_o_count !== 3'd0) begin errors++; $display("FAIL bub_empty got=%b/%0d exp=0/0", b_o_valid, b_o_count); end
   endtask

   task automatic test_back_to_back();
      a_o_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a_i_valid = 1'b1; a_i_data = 8'(i);
         step();
      end
      checks++; if (a_o_data !== 8'h00 || a_o_count !== 2'd3) begin errors++; $display("FAIL b2b_fill got=%h/%0d exp=00/3", a_o_data, a_o_count); end
      a_o_ready = 1'b1;
      for (int i = 3; i < 10; i++) begin
         a_i_data = 8'(i);
         #1;
         checks++; if (a_i_ready !== 1'b1) begin errors++; $display("FAIL b2b_iready[%0d] got=%b exp=1", i, a_i_ready); end
         step();
         checks++; if (a_o_valid !== 1'b1 || a_o_data !== 8'(i - 2)) begin errors++; $display("FAIL b2b_out[%0d] got=%b/%h exp=1/%h", i, a_o_valid, a_o_data, 8'(i - 2)); end
         checks++; if (a_o_count !== 2'd3) begin errors++; $display("FAIL b2b_count[%0d] got=%0d exp=3", i, a_o_count); end
      end
      a_i_valid = 1'b0;
      step();
      checks++; if (a_o_data !== 8'h08) begin errors++; $display("FAIL b2b_tail8 got=%h exp=08", a_o_data); end
      step();
      checks++; if (a_o_valid !== 1'b1 || a_o_data !== 8'h09) begin errors++; $display("FAIL b2b_tail9 got=%b/%h exp=1/09", a_o_valid, a_o_data); end
      step();
      checks++; if (a_o_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b exp=0", a_o_valid); end
   endtask

   task automatic test_flush();
      a_o_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a_i_valid = 1'b1; a_i_data = 8'hB1 + 8'(i);
         step();
      end
      a_o_ready = 1'b1;
      a_i_data  = 8'h77;
      a_i_flush = 1'b1;
      #1;
      checks++; if (a_o_valid !== 1'b1 || a_o_data !== 8'hB1) begin errors++; $display("FAIL fl_xfer got=%b/%h exp=1/b1", a_o_valid, a_o_data); end
      step();
      a_i_flush = 1'b0;
      a_i_valid = 1'b0;
      checks++; if (a_o_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got=%b exp=0", a_o_valid); end
      checks++; if (a_o_count !== 2'd0) begin errors++; $display("FAIL fl_count got=%0d exp=0", a_o_count); end
      checks++; if (a_i_ready !== 1'b1) begin errors++; $display("FAIL fl_iready got=%b exp=1", a_i_ready); end
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (a_o_valid !== 1'b0) begin errors++; $display("FAIL fl_no_leak[%0d] got=%b exp=0", i, a_o_valid); end
      end
   endtask

   task automatic test_reset_midstream();
      a_o_ready = 1'b0;
      a_i_valid = 1'b1; a_i_data = 8'hC1;
      step();
      a_i_data = 8'hC2;
      step();
      step();
      a_i_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checks++; if (a_o_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got=%b exp=0", a_o_valid); end
      checks++; if (a_o_count !== 2'd0) begin errors++; $display("FAIL mr_count got=%0d exp=0", a_o_count); end
      checks++; if (a_o_data !== 8'h00) begin errors++; $display("FAIL mr_data got=%h exp=00", a_o_data); end
      checks++; if (a_i_ready !== 1'b1) begin errors++; $display("FAIL mr_iready got=%b exp=1", a_i_ready); end
      #1;
      reset = 1'b0;
      a_o_ready = 1'b1;
      a_i_valid = 1'b1; a_i_data = 8'hD5;
      step();
      a_i_valid = 1'b0;
      checks++; if (a_o_valid !== 1'b0) begin errors++; $display("FAIL mr_lat1 got=%b exp=0", a_o_valid); end
      step();
      checks++; if (a_o_valid !== 1'b0) begin errors++; $display("FAIL mr_lat2 got=%b exp=0", a_o_valid); end
      step();
      checks++; if (a_o_valid !== 1'b1 || a_o_data !== 8'hD5) begin errors++; $display("FAIL mr_lat3 got=%b/%h exp=1/d5", a_o_valid, a_o_data); end
   endtask

   initial begin
      reset     = 1'b1;
      a_i_valid = 1'b0; a_i_data = '0; a_i_flush = 1'b0; a_o_ready = 1'b1;
      b_i_valid = 1'b0; b_i_data = '0; b_i_flush = 1'b0; b_o_ready = 1'b1;
      test_reset();
      test_latency();
      test_backpressure();
      test_bubble();
      test_back_to_back();
      test_flush();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
